// File: rtl/cnt_delta_accum.sv
// cnt_delta_accum: samples a 4-bit step counter, rebuilds the per-sample
// increment, accumulates it into a saturating wide total, and reports
// counter wrap-arounds as queued events on a valid/ready handshake.
module cnt_delta_accum #(
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned ACC_W    = 16,
   parameter int unsigned MAX_STEP = 2,
   parameter int unsigned PEND_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic              sample_en,
   input  logic              clear,
   output logic [ACC_W-1:0]  acc_o,
   output logic              wrap_valid_o,
   input  logic              wrap_ready_i,
   output logic [PEND_W-1:0] wrap_pend_o,
   output logic              step_err_o,
   output logic              acc_sat_o,
   output logic              wrap_drop_o
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic {
      UNPRIMED = 1'b0,
      RUN      = 1'b1
   } state_t;

   // Registered state
   state_t              state_q;
   logic [CNT_W-1:0]    prev_q;
   logic [ACC_W-1:0]    acc_q;
   logic [PEND_W-1:0]   pend_q;
   logic                valid_q;
   logic                step_err_q;
   logic                acc_sat_q;
   logic                wrap_drop_q;

   // Next-state values
   logic [CNT_W-1:0]    delta;
   logic                step_legal;
   logic                take;
   logic                wrap_evt;
   logic                pop;
   logic [SUM_W-1:0]    sum;
   logic [ACC_W-1:0]    acc_d;
   logic                sat_set;
   logic                err_set;
   logic [PEND_W-1:0]   pend_d;
   logic                drop_set;

   // Sequencing: UNPRIMED captures the baseline, RUN follows every sample
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_q <= UNPRIMED;
         prev_q  <= '0;
      end else if (sample_en) begin
         prev_q <= cnt_i;
         case (state_q)
            UNPRIMED: state_q <= RUN;
            RUN:      state_q <= RUN;
            default:  state_q <= UNPRIMED;
         endcase
      end
   end

   // Step reconstruction and classification of the current sample
   always_comb begin
      delta      = cnt_i - prev_q;
      step_legal = 32'(delta) <= MAX_STEP;
      take       = sample_en && (state_q == RUN);
      wrap_evt   = take && step_legal && (cnt_i < prev_q);
      pop        = valid_q && wrap_ready_i;
   end

   // Accumulator next value with saturation at all-ones
   always_comb begin
      acc_d   = acc_q;
      sat_set = 1'b0;
      err_set = 1'b0;
      sum     = {1'b0, acc_q} + SUM_W'(delta);
      if (take) begin
         if (!step_legal) begin
            err_set = 1'b1;
         end else if (acc_sat_q || sum[ACC_W]) begin
            acc_d   = '1;
            sat_set = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   // Pending wrap-event counter: push on wrap, pop on handshake
   always_comb begin
      pend_d   = pend_q;
      drop_set = 1'b0;
      case ({wrap_evt, pop})
         2'b10: begin
            if (pend_q == '1) begin
               drop_set = 1'b1;
            end else begin
               pend_d = pend_q + PEND_W'(1);
            end
         end
         2'b01:   pend_d = pend_q - PEND_W'(1);
         default: pend_d = pend_q;
      endcase
   end

   // Datapath registers; clear shares the reset path and beats any sample/pop
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         acc_q       <= '0;
         pend_q      <= '0;
         valid_q     <= 1'b0;
         step_err_q  <= 1'b0;
         acc_sat_q   <= 1'b0;
         wrap_drop_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         pend_q      <= pend_d;
         valid_q     <= (pend_d != '0);
         step_err_q  <= step_err_q  | err_set;
         acc_sat_q   <= acc_sat_q   | sat_set;
         wrap_drop_q <= wrap_drop_q | drop_set;
      end
   end

   assign acc_o        = acc_q;
   assign wrap_valid_o = valid_q;
   assign wrap_pend_o  = pend_q;
   assign step_err_o   = step_err_q;
   assign acc_sat_o    = acc_sat_q;
   assign wrap_drop_o  = wrap_drop_q;

endmodule

// File: tb/tb_cnt_delta_accum.sv
// Directed bench for cnt_delta_accum: a default-width instance plus a
// 4-bit-accumulator instance sharing the same stimulus for saturation.
module tb_cnt_delta_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cnt_i;
   logic        sample_en;
   logic        clear;
   logic        wrap_ready_i;

   logic [15:0] acc_o;
   logic        wrap_valid_o;
   logic [3:0]  wrap_pend_o;
   logic        step_err_o;
   logic        acc_sat_o;
   logic        wrap_drop_o;

   logic [3:0]  s_acc_o;
   logic        s_wrap_valid_o;
   logic [3:0]  s_wrap_pend_o;
   logic        s_step_err_o;
   logic        s_acc_sat_o;
   logic        s_wrap_drop_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cnt_delta_accum u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cnt_i        (cnt_i),
      .sample_en    (sample_en),
      .clear        (clear),
      .acc_o        (acc_o),
      .wrap_valid_o (wrap_valid_o),
      .wrap_ready_i (wrap_ready_i),
      .wrap_pend_o  (wrap_pend_o),
      .step_err_o   (step_err_o),
      .acc_sat_o    (acc_sat_o),
      .wrap_drop_o  (wrap_drop_o)
   );

   cnt_delta_accum #(.ACC_W(4)) u_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .cnt_i        (cnt_i),
      .sample_en    (sample_en),
      .clear        (clear),
      .acc_o        (s_acc_o),
      .wrap_valid_o (s_wrap_valid_o),
      .wrap_ready_i (wrap_ready_i),
      .wrap_pend_o  (s_wrap_pend_o),
      .step_err_o   (s_step_err_o),
      .acc_sat_o    (s_acc_sat_o),
      .wrap_drop_o  (s_wrap_drop_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [3:0] c);
      cnt_i     = c;
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_acc"},   32'(acc_o), 0);
      chk({tag, "_valid"}, 32'(wrap_valid_o), 0);
      chk({tag, "_pend"},  32'(wrap_pend_o), 0);
      chk({tag, "_err"},   32'(step_err_o), 0);
      chk({tag, "_sat"},   32'(acc_sat_o), 0);
      chk({tag, "_drop"},  32'(wrap_drop_o), 0);
      chk({tag, "_sacc"},  32'(s_acc_o), 0);
      chk({tag, "_ssat"},  32'(s_acc_sat_o), 0);
   endtask

   initial begin
      logic [15:0] exp_acc [5];
      logic [3:0]  prim_seq [5];
      prim_seq = '{4'd4, 4'd6, 4'd6, 4'd7, 4'd0};
      exp_acc  = '{16'd1, 16'd3, 16'd3, 16'd4, 16'd0};

      rst_n        = 1'b0;
      cnt_i        = '0;
      sample_en    = 1'b0;
      clear        = 1'b0;
      wrap_ready_i = 1'b0;

      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Prime and accumulate: 3,4,6,6,7 -> 0,1,3,3,4
      sample(4'd3);
      chk("prime_acc", 32'(acc_o), 0);
      for (int i = 0; i < 4; i++) begin
         sample(prim_seq[i]);
         chk("accum_acc", 32'(acc_o), 32'(exp_acc[i]));
         chk("accum_valid", 32'(wrap_valid_o), 0);
      end

      // Wrap event: 14,15,1,2 -> acc 4, one pending, then pop
      do_clear();
      sample(4'd14);
      sample(4'd15);
      chk("wrap_acc1", 32'(acc_o), 1);
      chk("wrap_nowrap", 32'(wrap_valid_o), 0);
      sample(4'd1);
      chk("wrap_acc3", 32'(acc_o), 3);
      chk("wrap_pend_a", 32'(wrap_pend_o), 1);
      sample(4'd2);
      chk("wrap_acc4", 32'(acc_o), 4);
      chk("wrap_pend_b", 32'(wrap_pend_o), 1);
      chk("wrap_valid", 32'(wrap_valid_o), 1);
      wrap_ready_i = 1'b1;
      tick();
      wrap_ready_i = 1'b0;
      chk("pop_pend", 32'(wrap_pend_o), 0);
      chk("pop_valid", 32'(wrap_valid_o), 0);

      // Illegal step: prime 2, sample 9, then 10
      do_clear();
      sample(4'd2);
      sample(4'd9);
      chk("illegal_err", 32'(step_err_o), 1);
      chk("illegal_acc", 32'(acc_o), 0);
      chk("illegal_nowrap", 32'(wrap_pend_o), 0);
      sample(4'd10);
      chk("rebase_acc", 32'(acc_o), 1);
      chk("rebase_err", 32'(step_err_o), 1);

      // Simultaneous push/pop and drop: each 15 -> 1 step is a legal wrap
      do_clear();
      sample(4'd15);
      for (int i = 0; i < 5; i++) begin
         sample(4'd1);
         sample(4'd15);
      end
      chk("pend5", 32'(wrap_pend_o), 5);
      wrap_ready_i = 1'b1;
      sample(4'd1);
      wrap_ready_i = 1'b0;
      chk("push_pop_pend", 32'(wrap_pend_o), 5);
      chk("push_pop_valid", 32'(wrap_valid_o), 1);
      for (int i = 0; i < 10; i++) begin
         sample(4'd15);
         sample(4'd1);
      end
      chk("pend15", 32'(wrap_pend_o), 15);
      chk("pend15_nodrop", 32'(wrap_drop_o), 0);
      sample(4'd15);
      sample(4'd1);
      chk("pend_full", 32'(wrap_pend_o), 15);
      chk("drop", 32'(wrap_drop_o), 1);

      // Saturation on the 4-bit accumulator instance
      do_clear();
      sample(4'd0);
      for (int i = 1; i <= 7; i++) sample(4'(2 * i));
      chk("sat_acc14", 32'(s_acc_o), 14);
      chk("sat_not_yet", 32'(s_acc_sat_o), 0);
      sample(4'd0);
      chk("sat_acc15", 32'(s_acc_o), 15);
      chk("sat_flag", 32'(s_acc_sat_o), 1);
      sample(4'd1);
      sample(4'd3);
      chk("sat_hold", 32'(s_acc_o), 15);
      chk("wide_acc", 32'(acc_o), 19);
      chk("wide_nosat", 32'(acc_sat_o), 0);
      chk("wide_pend", 32'(wrap_pend_o), 1);

      // Clear together with sample and pop
      cnt_i        = 4'd4;
      sample_en    = 1'b1;
      wrap_ready_i = 1'b1;
      clear        = 1'b1;
      tick();
      clear        = 1'b0;
      sample_en    = 1'b0;
      wrap_ready_i = 1'b0;
      chk_all_zero("clear");
      sample(4'd5);
      chk("clear_reprime", 32'(acc_o), 0);
      sample(4'd6);
      chk("clear_run", 32'(acc_o), 1);
      sample(4'd15);
      sample(4'd1);
      chk("pre_rst_pend", 32'(wrap_pend_o), 1);
      chk("pre_rst_err", 32'(step_err_o), 1);

      // Same sequence with reset for one edge
      cnt_i        = 4'd2;
      sample_en    = 1'b1;
      wrap_ready_i = 1'b1;
      rst_n        = 1'b0;
      tick();
      rst_n        = 1'b1;
      sample_en    = 1'b0;
      wrap_ready_i = 1'b0;
      chk_all_zero("rst");
      sample(4'd3);
      chk("rst_reprime", 32'(acc_o), 0);
      sample(4'd4);
      chk("rst_run", 32'(acc_o), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
